// File: rtl/vmem_pkg.sv
// Shared constants, FSM state type and lane address helpers for the vector
// memory bank scheduler.
package vmem_pkg;

   localparam int LANES  = 16;
   localparam int WORD_W = 16;
   localparam int ROW_W  = 11;
   localparam int BANK_W = 4;
   localparam int ADDR_W = ROW_W + BANK_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } vmem_state_t;

   // Word address of one lane; the stride is signed but only its low bits
   // matter because the address space wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] lane_word_addr(
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] stride,
      input int unsigned       lane
   );
      logic [ADDR_W-1:0] idx;
      idx = ADDR_W'(lane);
      return base + idx * stride;
   endfunction

   function automatic logic [BANK_W-1:0] word_bank(input logic [ADDR_W-1:0] wa);
      return wa[BANK_W-1:0];
   endfunction

endpackage

// File: rtl/vmem_bank_pick.sv
// Per-bank priority picker: for every bank, grants the lowest-numbered
// pending lane that maps to it.
module vmem_bank_pick
   import vmem_pkg::*;
(
   input  logic [LANES-1:0]             pending_i,
   input  logic [LANES-1:0][BANK_W-1:0] lane_bank_i,
   output logic [LANES-1:0][LANES-1:0]  grant_o,
   output logic [LANES-1:0]             valid_o,
   output logic [LANES-1:0][BANK_W-1:0] tag_o
);

   always_comb begin
      // NOTE: every output gets a default before the loops, otherwise banks with
      // no pending lane would hold their old value and infer latches.
      grant_o = '0;
      valid_o = '0;
      tag_o   = '0;
      // Scanning from the top lane down lets the lowest matching lane win.
      for (int b = 0; b < LANES; b++) begin
         for (int l = LANES - 1; l >= 0; l--) begin
            if (pending_i[l] && (lane_bank_i[l] == BANK_W'(b))) begin
               grant_o[b]    = '0;
               grant_o[b][l] = 1'b1;
               valid_o[b]    = 1'b1;
               tag_o[b]      = BANK_W'(l);
            end
         end
      end
   end

endmodule

// File: rtl/vmem_bank_sched.sv
// Strided vector load/store scheduler: issues at most one access per bank per
// cycle, serialises bank conflicts and gathers load data into one vector.
module vmem_bank_sched #(
   parameter int LANES  = 16,
   parameter int WORD_W = 16,
   parameter int ROW_W  = 11
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_is_store,
   input  logic [15:0]               req_base,
   input  logic [15:0]               req_stride,
   input  logic [LANES*WORD_W-1:0]   req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [LANES*WORD_W-1:0]   rsp_rdata,
   output logic [4:0]                rsp_issue_cycles,
   output logic [LANES-1:0]          bank_ren,
   output logic [LANES*ROW_W-1:0]    bank_raddr,
   input  logic [LANES*WORD_W-1:0]   bank_rdata,
   output logic [LANES-1:0]          bank_wen,
   output logic [LANES*ROW_W-1:0]    bank_waddr,
   output logic [LANES*WORD_W-1:0]   bank_wdata,
   output logic                      busy
);

   import vmem_pkg::BANK_W, vmem_pkg::vmem_state_t, vmem_pkg::IDLE, vmem_pkg::ISSUE,
          vmem_pkg::DRAIN, vmem_pkg::RESP, vmem_pkg::lane_word_addr, vmem_pkg::word_bank;

   localparam int AW = ROW_W + BANK_W;

   vmem_state_t                  state_q, state_d;
   logic [LANES-1:0]             pending_q, pending_d;
   logic [AW-1:0]                base_q, base_d;
   logic [AW-1:0]                stride_q, stride_d;
   logic                         store_q, store_d;
   logic [LANES-1:0][WORD_W-1:0] wdata_q, wdata_d;
   logic [LANES-1:0][WORD_W-1:0] rdata_q, rdata_d;
   logic [4:0]                   issue_cnt_q, issue_cnt_d;
   logic [LANES-1:0]             rd_vld_q;
   logic [LANES-1:0][BANK_W-1:0] rd_tag_q;

   logic [LANES-1:0][AW-1:0]     wa;
   logic [LANES-1:0][BANK_W-1:0] lane_bank;
   logic [LANES-1:0][LANES-1:0]  pick_grant;
   logic [LANES-1:0]             pick_valid;
   logic [LANES-1:0][BANK_W-1:0] pick_tag;
   logic [LANES-1:0]             granted;
   logic                         accept;
   logic                         unused_bits;

   // Byte-address LSB is ignored and the stride sign bit vanishes modulo 2^15.
   assign unused_bits = req_base[0] ^ req_stride[15];

   assign accept           = req_valid && (state_q == IDLE);
   assign req_ready        = (state_q == IDLE);
   assign busy             = (state_q != IDLE);
   assign rsp_valid        = (state_q == RESP);
   assign rsp_rdata        = rdata_q;
   assign rsp_issue_cycles = issue_cnt_q;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         wa[l]        = lane_word_addr(base_q, stride_q, l);
         lane_bank[l] = word_bank(wa[l]);
      end
   end

   vmem_bank_pick u_pick (
      .pending_i   (pending_q),
      .lane_bank_i (lane_bank),
      .grant_o     (pick_grant),
      .valid_o     (pick_valid),
      .tag_o       (pick_tag)
   );

   always_comb begin
      granted = '0;
      for (int b = 0; b < LANES; b++) granted |= pick_grant[b];
   end

   // Bank ports are decoded from registered state only, so a reset clears them at once.
   always_comb begin
      bank_ren   = '0;
      bank_wen   = '0;
      bank_raddr = '0;
      bank_waddr = '0;
      bank_wdata = '0;
      if (state_q == ISSUE) begin
         for (int b = 0; b < LANES; b++) begin
            if (pick_valid[b]) begin
               if (store_q) begin
                  bank_wen[b]                   = 1'b1;
                  bank_waddr[b*ROW_W +: ROW_W]  = wa[pick_tag[b]][AW-1:BANK_W];
                  bank_wdata[b*WORD_W +: WORD_W] = wdata_q[pick_tag[b]];
               end else begin
                  bank_ren[b]                   = 1'b1;
                  bank_raddr[b*ROW_W +: ROW_W]  = wa[pick_tag[b]][AW-1:BANK_W];
               end
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = ISSUE;
         ISSUE:   if ((pending_q & ~granted) == '0) state_d = store_q ? RESP : DRAIN;
         DRAIN:   state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pending_d   = pending_q;
      base_d      = base_q;
      stride_d    = stride_q;
      store_d     = store_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      issue_cnt_d = issue_cnt_q;
      if (accept) begin
         base_d      = req_base[15:1];
         stride_d    = req_stride[AW-1:0];
         store_d     = req_is_store;
         wdata_d     = req_wdata;
         pending_d   = '1;
         rdata_d     = '0;
         issue_cnt_d = '0;
      end
      if (state_q == ISSUE) begin
         pending_d   = pending_q & ~granted;
         issue_cnt_d = issue_cnt_q + 5'd1;
      end
      // Read data returns one cycle after the enable; steer it by the saved lane tag.
      for (int b = 0; b < LANES; b++) begin
         if (rd_vld_q[b]) rdata_d[rd_tag_q[b]] = bank_rdata[b*WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples
         // the pre-edge values regardless of process evaluation order.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= '0;
         base_q      <= '0;
         stride_q    <= '0;
         store_q     <= 1'b0;
         wdata_q     <= '0;
         // NOTE: the gather vector is reset like any flop because its value is
         // visible on rsp_rdata straight out of reset.
         rdata_q     <= '0;
         issue_cnt_q <= '0;
         rd_vld_q    <= '0;
         rd_tag_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         base_q      <= base_d;
         stride_q    <= stride_d;
         store_q     <= store_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         issue_cnt_q <= issue_cnt_d;
         rd_vld_q    <= bank_ren;
         rd_tag_q    <= pick_tag;
      end
   end

endmodule

// File: tb/tb_vmem_bank_sched.sv
// Self-checking bench for vmem_bank_sched: directed corner cases plus random
// strided requests against a word-level memory and request model.
module tb_vmem_bank_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_is_store = 1'b0;
   logic [15:0]  req_base = '0;
   logic [15:0]  req_stride = '0;
   logic [255:0] req_wdata = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [255:0] rsp_rdata;
   logic [4:0]   rsp_issue_cycles;
   logic [15:0]  bank_ren;
   logic [175:0] bank_raddr;
   logic [255:0] bank_rdata = '0;
   logic [15:0]  bank_wen;
   logic [175:0] bank_waddr;
   logic [255:0] bank_wdata;
   logic         busy;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem     [0:32767];
   logic [15:0] ref_mem [0:32767];

   always #5 clk = ~clk;

   vmem_bank_sched #(.LANES(16), .WORD_W(16), .ROW_W(11)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_is_store     (req_is_store),
      .req_base         (req_base),
      .req_stride       (req_stride),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_rdata        (rsp_rdata),
      .rsp_issue_cycles (rsp_issue_cycles),
      .bank_ren         (bank_ren),
      .bank_raddr       (bank_raddr),
      .bank_rdata       (bank_rdata),
      .bank_wen         (bank_wen),
      .bank_waddr       (bank_waddr),
      .bank_wdata       (bank_wdata),
      .busy             (busy)
   );

   // Sixteen synchronous banks with one-cycle read latency.
   always @(posedge clk) begin
      for (int b = 0; b < 16; b++) begin
         if (bank_wen[b]) mem[{bank_waddr[b*11 +: 11], 4'(b)}] <= bank_wdata[b*16 +: 16];
         if (bank_ren[b]) bank_rdata[b*16 +: 16] <= mem[{bank_raddr[b*11 +: 11], 4'(b)}];
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input bit st, input logic [15:0] base, input logic [15:0] stride,
                          input logic [255:0] wd, input int hold, input string tag);
      logic [14:0]  wa [16];
      int           cnt [16];
      int           n, distinct, lat, issue_seen, first_en;
      logic [31:0]  x;
      logic [255:0] exp_rd, held, got, want;
      for (int b = 0; b < 16; b++) cnt[b] = 0;
      exp_rd = '0;
      for (int i = 0; i < 16; i++) begin
         x     = 32'(base[15:1]) + 32'(i) * 32'(stride);
         wa[i] = x[14:0];
         cnt[wa[i] % 16]++;
         if (!st) exp_rd[i*16 +: 16] = ref_mem[wa[i]];
      end
      n = 0;
      distinct = 0;
      for (int b = 0; b < 16; b++) begin
         if (cnt[b] > n) n = cnt[b];
         if (cnt[b] > 0) distinct++;
      end

      @(negedge clk);
      check({tag, "_req_ready"}, 256'(req_ready), 256'(1));
      req_valid    = 1'b1;
      req_is_store = st;
      req_base     = base;
      req_stride   = stride;
      req_wdata    = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_wdata = ~wd;

      lat = 0;
      issue_seen = 0;
      first_en = -1;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if ((bank_ren | bank_wen) != '0) begin
            issue_seen++;
            if (first_en < 0) first_en = $countones(bank_ren | bank_wen);
            check({tag, "_wrong_dir"}, 256'(st ? bank_ren : bank_wen), 256'(0));
         end
         if (rsp_valid) lat = k;
      end
      check({tag, "_latency"}, 256'(lat), 256'(st ? n + 1 : n + 2));
      check({tag, "_issue_seen"}, 256'(issue_seen), 256'(n));
      check({tag, "_first_en"}, 256'(first_en), 256'(distinct));
      check({tag, "_issue_cycles"}, 256'(rsp_issue_cycles), 256'(n));
      check({tag, "_rdata"}, rsp_rdata, exp_rd);

      held = exp_rd;
      if (hold > 0) begin
         req_valid = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 256'(rsp_valid), 256'(1));
            check({tag, "_hold_rdata"}, rsp_rdata, held);
            check({tag, "_hold_req_ready"}, 256'(req_ready), 256'(0));
         end
         req_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check({tag, "_done_valid"}, 256'(rsp_valid), 256'(0));
      check({tag, "_done_ready"}, 256'(req_ready), 256'(1));

      if (st) begin
         for (int i = 0; i < 16; i++) ref_mem[wa[i]] = wd[i*16 +: 16];
         for (int i = 0; i < 16; i++) begin
            got[i*16 +: 16]  = mem[wa[i]];
            want[i*16 +: 16] = ref_mem[wa[i]];
         end
         check({tag, "_mem"}, got, want);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] wd;
      logic [15:0]  rb, rs;
      for (int a = 0; a < 32768; a++) begin
         mem[a]     = 16'(a * 16'h9E37) ^ 16'h5A3C;
         ref_mem[a] = 16'(a * 16'h9E37) ^ 16'h5A3C;
      end

      #1;
      check("reset_req_ready", 256'(req_ready), 256'(1));
      check("reset_rsp_valid", 256'(rsp_valid), 256'(0));
      check("reset_rdata", rsp_rdata, 256'(0));
      check("reset_issue_cycles", 256'(rsp_issue_cycles), 256'(0));
      check("reset_enables", 256'({bank_ren, bank_wen}), 256'(0));
      check("reset_raddr", 256'(bank_raddr), 256'(0));
      check("reset_waddr", 256'(bank_waddr), 256'(0));
      check("reset_wdata", bank_wdata, 256'(0));
      check("reset_busy", 256'(busy), 256'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_req(1'b0, 16'h0100, 16'h0001, '0, 0, "ld_stride1");
      run_req(1'b0, 16'h0100, 16'h0010, '0, 0, "ld_stride16");

      for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'h1000 + 16'(i);
      run_req(1'b1, 16'h0040, 16'h0000, wd, 0, "st_stride0");
      check("st_stride0_final_word", 256'(mem[15'h0020]), 256'(16'h100F));

      run_req(1'b0, 16'h0000, 16'hFFFF, '0, 0, "ld_wrap");

      for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
      run_req(1'b1, 16'h0200, 16'h0002, wd, 5, "st_stride2_hold");

      // Reset in the third ISSUE cycle of a fully conflicting load.
      @(negedge clk);
      req_valid  = 1'b1;
      req_is_store = 1'b0;
      req_base   = 16'h0300;
      req_stride = 16'h0010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_issuing", 256'($countones(bank_ren)), 256'(1));
      rst_n = 1'b0;
      #1;
      check("rst_mid_enables", 256'({bank_ren, bank_wen}), 256'(0));
      check("rst_mid_busy", 256'(busy), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_after_req_ready", 256'(req_ready), 256'(1));
      check("rst_after_rsp_valid", 256'(rsp_valid), 256'(0));
      check("rst_after_issue_cycles", 256'(rsp_issue_cycles), 256'(0));
      run_req(1'b0, 16'h0100, 16'h0001, '0, 0, "ld_after_rst");

      for (int t = 0; t < 24; t++) begin
         rb = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       rs = 16'($urandom);
            1:       rs = 16'($urandom_range(0, 4));
            2:       rs = 16'(1 << $urandom_range(0, 4));
            default: rs = -16'($urandom_range(1, 4));
         endcase
         for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
         run_req(1'($urandom_range(0, 1)), rb, rs, wd, int'($urandom_range(0, 2)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vmem_bank_sched.md
# vmem_bank_sched

Vector memory access scheduler between the CPU's vector load/store path and the sixteen 16-bit data-memory banks. It accepts one strided vector request: 16 lanes of 16-bit words, base address plus stride. Each cycle it issues at most one access per bank, serialising lanes that collide on a bank. For loads it gathers the returned words into a 256-bit vector-register value.

## Interface
Parameters:
- `LANES`, default 16: vector lanes, equal to the number of banks; only 16 is supported.
- `WORD_W`, default 16: lane and bank word width.
- `ROW_W`, default 11: bank row-address width (15-bit word address minus 4 bank bits).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: vector request present.
- `req_ready` out 1: scheduler idle; request accepted on `req_valid && req_ready`.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_base` in 16: byte address; bit 0 ignored.
- `req_stride` in 16: signed word stride.
- `req_wdata` in 256: store data; lane i is bits [16i+15:16i].
- `rsp_valid` out 1: request complete.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 256: gathered load data; 0 for stores.
- `rsp_issue_cycles` out 5: number of ISSUE cycles used (1..16).
- `bank_ren` out 16: per-bank read enable.
- `bank_raddr` out 176: per-bank row, bank b is bits [11b+10:11b].
- `bank_rdata` in 256: per-bank read data, valid the cycle after `bank_ren`.
- `bank_wen` out 16: per-bank write enable.
- `bank_waddr` out 176: per-bank write row.
- `bank_wdata` out 256: per-bank write data.
- `busy` out 1: high in any state except IDLE.

## Operation
- Lane word address: `wa_i = req_base[15:1] + i*req_stride`, modulo 2^15 (wraps, no error). Bank = `wa_i[3:0]`, row = `wa_i[14:4]`.
- Accept latches base, stride, store flag and wdata, and sets `pending` = 16'hFFFF.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
  - IDLE → ISSUE on accept.
  - ISSUE → ISSUE while `pending` is non-zero after this cycle's grants.
  - ISSUE → DRAIN when the last lanes are granted (loads).
  - ISSUE → RESP when the last lanes are granted (stores).
  - DRAIN → RESP unconditionally.
  - RESP → IDLE on `rsp_ready`.
- ISSUE cycle, per bank b: grant the lowest-numbered pending lane mapping to b. Drive that bank's enable, row and (store) data. Clear the granted lanes from `pending`.
- A granted-lane tag is registered per bank. Next cycle, `bank_rdata[b]` is written into `rsp_rdata` lane[tag].
- No address merging. Lanes with identical addresses are issued in separate cycles, lowest lane first. Stride-0 stores therefore leave lane 15's data in memory.
- `rsp_issue_cycles` equals the maximum count of lanes mapping to one bank.
- Bank enables are combinational from registered state. They are 0 outside ISSUE, and `bank_ren`/`bank_wen` are never both set.

## Timing
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_issue_cycles`=0, all bank enables and addresses/data 0, `busy`=0, `pending`=0.
- Request accepted at edge T, N = issue count:
  - ISSUE occupies cycles T+1..T+N.
  - Store: `rsp_valid` rises in cycle T+N+1.
  - Load: DRAIN is cycle T+N+1 and `rsp_valid` rises in cycle T+N+2.
- Minimum latency is 2 cycles (store) or 3 cycles (load), conflict-free.
- `rsp_valid` and `rsp_rdata` are held stable until `rsp_ready`. The next request can be accepted one cycle after the response handshake; `req_ready` is asserted only in IDLE.
- `rsp_rdata` is cleared on accept, so unrelated lanes never leak from the previous load.
- Reset mid-operation: all enables drop immediately (asynchronous), pending work is discarded and the FSM returns to IDLE; no partial response is produced.

## Structure
- Shared package `vmem_pkg`: `LANES`, `WORD_W`, `ROW_W`, `BANK_W`=4, the state enum `vmem_state_t` {IDLE, ISSUE, DRAIN, RESP}, and a lane-index function for bank mapping.
- Sub-module `vmem_bank_pick`: combinational 16-lane priority picker. Inputs are the pending mask and per-lane bank indices. Outputs are, per bank, a one-hot grant, a valid bit and a 4-bit lane tag. It is instantiated once.

## Test plan
- Load, base 0x0100, stride 1: one issue cycle, all 16 `bank_ren` high in a single cycle, `rsp_valid` at T+3, `rsp_issue_cycles`=1, lanes match memory words 0x80..0x8F.
- Load, stride 16: all lanes hit the bank of `wa_0`, 16 issue cycles with one `bank_ren` bit each, `rsp_valid` at T+18, `rsp_issue_cycles`=16.
- Store, stride 0, base 0x0040, lane i data = 0x1000+i: 16 sequential writes to bank 0 row 2, final word 0x100F, `rsp_valid` at T+17, `rsp_rdata`=0.
- Load, base 0, stride -1 (0xFFFF): lane 1 goes to word 0x7FFF (bank 15, row 0x7FF), showing wrap; 1 issue cycle.
- Store stride 2: 2 issue cycles. Hold `rsp_ready` low 5 cycles: `rsp_valid` and data stay stable, `req_ready`=0, and a second `req_valid` is not accepted until IDLE.
- Assert `rst_n` low during the 3rd ISSUE cycle of a stride-16 load: enables drop asynchronously, after release `req_ready`=1 and `rsp_valid`=0, and a fresh stride-1 load completes normally.
